tcam_route_lookup: RTL and testbench

Small ternary-match route table for IPv4 longest-prefix-match forwarding in the router datapath.
- Holds SIZE entries of {interface index, netmask, prefix}, written one at a time.
- Each lookup compares an address against all entries in parallel.
- Returns the next hop (the matching network), the egress interface and the prefix length of the longest match.
- Brute-force parallel compare, sized for small route tables.

---
 rtl/tcam_pkg.sv | 25 ++
 rtl/tcam_lpm_select.sv | 53 +++++
 rtl/tcam_route_lookup.sv | 119 +++++++++++
 tb/tb_tcam_route_lookup.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared constants, entry layout and helpers for the ternary route table.
package tcam_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned IF_W     = 4;
    localparam int unsigned IF_LSB   = 64;
    localparam int unsigned MASK_LSB = 32;
    localparam int unsigned PFX_LSB  = 0;

    typedef struct packed {
        logic [IF_W-1:0]  if_idx;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] prefix;
    } entry_t;

    function automatic logic [7:0] popcount(input logic [WIDTH-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt = cnt + 8'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tcam_lpm_select.sv
// Longest-prefix winner selection: reduction tree over match bits and popcounts,
// lowest index wins on equal popcount.
module tcam_lpm_select
    import tcam_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic [SIZE-1:0]      match,
    input  logic [SIZE-1:0][7:0] pop,
    output logic [IDX_W-1:0]     win_idx,
    output logic                 hit
);

    localparam int unsigned LVLS = IDX_W;
    localparam int unsigned P    = 1 << IDX_W;

    logic             node_hit [P];
    logic [7:0]       node_pop [P];
    logic [IDX_W-1:0] node_idx [P];

    always_comb begin
        for (int i = 0; i < int'(P); i++) begin
            if (i < int'(SIZE)) begin
                node_hit[i] = match[i];
                node_pop[i] = pop[i];
            end else begin
                node_hit[i] = 1'b0;
                node_pop[i] = '0;
            end
            node_idx[i] = IDX_W'(i);
        end
        // In-place pairwise reduction; node i at each level reads 2i and 2i+1, which are
        // never overwritten before being read. Left child covers lower indices.
        for (int l = 0; l < int'(LVLS); l++) begin
            for (int i = 0; i < int'(P >> (l + 1)); i++) begin
                if (node_hit[2*i] &&
                    (!node_hit[2*i+1] || node_pop[2*i] >= node_pop[2*i+1])) begin
                    node_hit[i] = node_hit[2*i];
                    node_pop[i] = node_pop[2*i];
                    node_idx[i] = node_idx[2*i];
                end else begin
                    node_hit[i] = node_hit[2*i+1];
                    node_pop[i] = node_pop[2*i+1];
                    node_idx[i] = node_idx[2*i+1];
                end
            end
        end
        hit     = node_hit[0];
        win_idx = node_idx[0];
    end

endmodule

// File: rtl/tcam_route_lookup.sv
// Small ternary route table: parallel masked compare of all entries, longest prefix
// wins, outputs registered one cycle after the lookup edge.
module tcam_route_lookup #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 8,
    parameter int unsigned IF_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [7:0]              wr_index,
    input  logic [2*WIDTH+IF_W-1:0] addr_in,
    output logic [WIDTH-1:0]        addr_out,
    output logic [IF_W-1:0]         if_idx,
    output logic [7:0]              prefix_size,
    output logic                    valid
);

    import tcam_pkg::*;

    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    entry_t            entries_q [SIZE];
    entry_t            entries_d [SIZE];
    logic [SIZE-1:0]   ent_valid_q, ent_valid_d;

    logic [SIZE-1:0]      match;
    logic [SIZE-1:0][7:0] ent_pop;
    logic [IDX_W-1:0]     win_idx;
    logic                 hit;
    entry_t               win;

    logic [WIDTH-1:0] addr_out_q, addr_out_d;
    logic [IF_W-1:0]  if_idx_q, if_idx_d;
    logic [7:0]       prefix_size_q, prefix_size_d;
    logic             valid_q, valid_d;

    // Out-of-range indices simply match no entry, so those writes are dropped.
    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            entries_d[i]   = entries_q[i];
            ent_valid_d[i] = ent_valid_q[i];
            if (wr_en && wr_index == 8'(i)) begin
                entries_d[i].if_idx = addr_in[IF_LSB +: IF_W];
                entries_d[i].mask   = addr_in[MASK_LSB +: WIDTH];
                entries_d[i].prefix = addr_in[PFX_LSB +: WIDTH];
                ent_valid_d[i]      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            match[i] = ent_valid_q[i] &&
                       ((addr_in[WIDTH-1:0] & entries_q[i].mask) ==
                        (entries_q[i].prefix & entries_q[i].mask));
            ent_pop[i] = popcount(entries_q[i].mask);
        end
    end

    tcam_lpm_select #(
        .SIZE (SIZE)
    ) u_select (
        .match   (match),
        .pop     (ent_pop),
        .win_idx (win_idx),
        .hit     (hit)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            if (win_idx == IDX_W'(i)) begin
                win = entries_q[i];
            end
        end
    end

    always_comb begin
        addr_out_d    = addr_out_q;
        if_idx_d      = if_idx_q;
        prefix_size_d = prefix_size_q;
        valid_d       = valid_q;
        if (!wr_en) begin
            valid_d       = hit;
            addr_out_d    = hit ? (win.prefix & win.mask) : '0;
            if_idx_d      = hit ? win.if_idx : '0;
            prefix_size_d = hit ? popcount(win.mask) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                entries_q[i] <= '0;
            end
            ent_valid_q   <= '0;
            addr_out_q    <= '0;
            if_idx_q      <= '0;
            prefix_size_q <= '0;
            valid_q       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SIZE); i++) begin
                entries_q[i] <= entries_d[i];
            end
            ent_valid_q   <= ent_valid_d;
            addr_out_q    <= addr_out_d;
            if_idx_q      <= if_idx_d;
            prefix_size_q <= prefix_size_d;
            valid_q       <= valid_d;
        end
    end

    assign addr_out    = addr_out_q;
    assign if_idx      = if_idx_q;
    assign prefix_size = prefix_size_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_tcam_route_lookup.sv
// Self-checking bench: directed route-table scenarios plus randomized traffic
// checked against a simple longest-prefix reference model.
module tb_tcam_route_lookup;

    localparam int SIZE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_index;
    logic [67:0] addr_in;
    logic [31:0] addr_out;
    logic [3:0]  if_idx;
    logic [7:0]  prefix_size;
    logic        valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mask [SIZE];
    logic [31:0] m_pfx  [SIZE];
    logic [3:0]  m_if   [SIZE];
    bit          m_val  [SIZE];

    logic        e_v;
    logic [31:0] e_a;
    logic [3:0]  e_if;
    logic [7:0]  e_ps;

    tcam_route_lookup #(
        .WIDTH (32),
        .SIZE  (SIZE),
        .IF_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .addr_in     (addr_in),
        .addr_out    (addr_out),
        .if_idx      (if_idx),
        .prefix_size (prefix_size),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic check_outs(input string tag);
        checks++;
        assert (valid === e_v) else begin
            errors++;
            $error("FAIL %s valid: got %0b expected %0b", tag, valid, e_v);
        end
        checks++;
        assert (addr_out === e_a) else begin
            errors++;
            $error("FAIL %s addr_out: got %h expected %h", tag, addr_out, e_a);
        end
        checks++;
        assert (if_idx === e_if) else begin
            errors++;
            $error("FAIL %s if_idx: got %0d expected %0d", tag, if_idx, e_if);
        end
        checks++;
        assert (prefix_size === e_ps) else begin
            errors++;
            $error("FAIL %s prefix_size: got %0d expected %0d", tag, prefix_size, e_ps);
        end
    endtask

    task automatic set_exp(input logic v, input logic [31:0] a, input logic [3:0] ifx,
                           input logic [7:0] ps);
        e_v  = v;
        e_a  = a;
        e_if = ifx;
        e_ps = ps;
    endtask

    // Reference: scan all valid entries, keep the strictly longest mask seen first.
    task automatic model_lookup(input logic [31:0] a);
        int best, best_len, len;
        best = -1;
        best_len = -1;
        for (int i = 0; i < SIZE; i++) begin
            if (m_val[i] && ((a & m_mask[i]) == (m_pfx[i] & m_mask[i]))) begin
                len = $countones(m_mask[i]);
                if (len > best_len) begin
                    best = i;
                    best_len = len;
                end
            end
        end
        if (best < 0) set_exp(1'b0, '0, '0, '0);
        else set_exp(1'b1, m_pfx[best] & m_mask[best], m_if[best], 8'(best_len));
    endtask

    task automatic model_clear();
        for (int i = 0; i < SIZE; i++) begin
            m_mask[i] = '0;
            m_pfx[i]  = '0;
            m_if[i]   = '0;
            m_val[i]  = 1'b0;
        end
    endtask

    // Every write also checks that outputs held the previous lookup result.
    task automatic do_write(input int idx, input logic [3:0] ifx, input logic [31:0] mask,
                            input logic [31:0] pfx, input string tag);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_index = 8'(idx);
        addr_in  = {ifx, mask, pfx};
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (idx < SIZE) begin
            m_if[idx]   = ifx;
            m_mask[idx] = mask;
            m_pfx[idx]  = pfx;
            m_val[idx]  = 1'b1;
        end
        check_outs(tag);
    endtask

    task automatic drive_lookup(input logic [31:0] a);
        @(negedge clk);
        wr_en   = 1'b0;
        addr_in = {4'($urandom), $urandom, a};
        @(posedge clk);
        #1;
    endtask

    task automatic plan_lookup(input logic [31:0] a, input logic v, input logic [31:0] ao,
                               input logic [3:0] ifx, input logic [7:0] ps, input string tag);
        drive_lookup(a);
        set_exp(v, ao, ifx, ps);
        check_outs(tag);
    endtask

    task automatic rand_lookup(input logic [31:0] a);
        drive_lookup(a);
        model_lookup(a);
        check_outs("rand_lookup");
    endtask

    initial begin
        logic [31:0] mask, pfx, a;
        int k, len;

        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_index = '0;
        addr_in  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        set_exp(1'b0, '0, '0, '0);
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        plan_lookup(32'hc0a80001, 1'b0, '0, '0, '0, "empty_table");

        do_write(0, 4'd1, 32'hffffff00, 32'hc0a80000, "wr_e0");
        do_write(1, 4'd2, 32'hffffffe0, 32'hc0a80000, "wr_e1");
        do_write(2, 4'd3, 32'hff000000, 32'h0a000000, "wr_e2");
        plan_lookup(32'hc0a8000a, 1'b1, 32'hc0a80000, 4'd2, 8'd27, "lpm_27");
        plan_lookup(32'hc0a8003c, 1'b1, 32'hc0a80000, 4'd1, 8'd24, "lpm_24");
        plan_lookup(32'hc0a80101, 1'b0, '0, '0, '0, "miss");
        plan_lookup(32'h0a000a02, 1'b1, 32'h0a000000, 4'd3, 8'd8, "lpm_8");

        do_write(3, 4'd0, 32'h00000000, 32'h00000000, "wr_default");
        plan_lookup(32'hc0a80101, 1'b1, '0, 4'd0, 8'd0, "default_route");

        do_write(5, 4'd5, 32'hffffffe0, 32'hc0a80000, "wr_tie");
        plan_lookup(32'hc0a8001e, 1'b1, 32'hc0a80000, 4'd2, 8'd27, "tie_low_index");

        do_write(9, 4'd7, 32'hffffffff, 32'hc0a8000a, "wr_out_of_range_hold");
        plan_lookup(32'hc0a8000a, 1'b1, 32'hc0a80000, 4'd2, 8'd27, "out_of_range_ignored");

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        set_exp(1'b0, '0, '0, '0);
        check_outs("async_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        plan_lookup(32'hc0a8000a, 1'b0, '0, '0, '0, "after_reset");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    mask = $urandom;
                end else begin
                    len  = int'($urandom_range(0, 32));
                    mask = (len == 0) ? 32'h0 : (32'hffffffff << (32 - len));
                end
                pfx = $urandom;
                do_write(int'($urandom_range(0, 10)), 4'($urandom), mask, pfx, "rand_write");
            end else begin
                k = int'($urandom_range(0, SIZE - 1));
                if ($urandom_range(0, 3) == 0) a = $urandom;
                else a = (m_pfx[k] & m_mask[k]) | ($urandom & ~m_mask[k]);
                rand_lookup(a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
